// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and queued LSU loads onto the regfile write port.
// Optional WB_FWD_EN adds a youngest-wins forwarding lookup over the queue and output register.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata,
    output logic            regwen,
`ifdef WB_FWD_EN
    input  logic [4:0]      fwd_addr,
    output logic            fwd_hit,
    output logic [XLEN-1:0] fwd_data,
`endif
    output logic            pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]      r_rd  [DEPTH];
    logic [XLEN-1:0] r_dat [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_regwen;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic            r_pending;

    logic            w_empty;
    logic            w_pop;
    logic            w_bypass;
    logic            w_push;
    logic            w_sel_v;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic [CW-1:0]   w_count_nxt;

    assign w_empty   = (r_count == '0);
    assign lsu_ready = (r_count != FULL);
    assign w_pop     = !alu_valid && !w_empty;
    assign w_bypass  = !alu_valid && w_empty && lsu_valid;
    assign w_push    = lsu_valid && lsu_ready && !w_bypass;
    assign w_sel_v   = alu_valid || w_pop || w_bypass;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        unique case (1'b1)
            alu_valid: begin
                w_sel_rd   = alu_rd;
                w_sel_data = alu_data;
            end
            w_pop: begin
                w_sel_rd   = r_rd[r_rptr];
                w_sel_data = r_dat[r_rptr];
            end
            w_bypass: begin
                w_sel_rd   = lsu_rd;
                w_sel_data = lsu_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (w_pop && !w_push)
            w_count_nxt = r_count - 1'b1;
    end

    // Storage is not reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wptr]  <= lsu_rd;
            r_dat[r_wptr] <= lsu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_pending <= 1'b0;
            r_regwen  <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count   <= w_count_nxt;
            r_pending <= (w_count_nxt != '0);
            // x0 results are consumed but never written.
            if (w_sel_v && (w_sel_rd != 5'd0)) begin
                r_regwen <= 1'b1;
                r_waddr  <= w_sel_rd;
                r_wdata  <= w_sel_data;
            end else begin
                r_regwen <= 1'b0;
            end
        end
    end

    assign regwen  = r_regwen;
    assign waddr   = r_waddr;
    assign wdata   = r_wdata;
    assign pending = r_pending;

`ifdef WB_FWD_EN
    // Oldest candidate first, so later (younger) matches override.
    always_comb begin : fwd_lookup
        logic [AW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        if (fwd_addr != 5'd0) begin
            if (r_regwen && (r_waddr == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_wdata;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = r_rptr + AW'(i);
                if ((CW'(i) < r_count) && (r_rd[idx] == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = r_dat[idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, directed sequences and
// randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alu_valid = 1'b0;
    logic [4:0]      alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            lsu_valid = 1'b0;
    logic [4:0]      lsu_rd = '0;
    logic [XLEN-1:0] lsu_data = '0;
    logic            lsu_ready;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic            regwen;
    logic            pending;
`ifdef WB_FWD_EN
    logic [4:0]      fwd_addr = '0;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
`endif

    wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_ready(lsu_ready),
        .waddr(waddr), .wdata(wdata), .regwen(regwen),
`ifdef WB_FWD_EN
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
        .pending(pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_init = 1'b0;
    logic        m_regwen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] ard,
                         input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                         input logic [31:0] ld);
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    endtask

    // Reference: one write per cycle, ALU first, then queue head, then direct LSU.
    task automatic model_step();
        ent_t sel;
        logic have;
        logic byp;
        logic rdy;
        have = 1'b0; byp = 1'b0;
        sel.rd = '0; sel.d = '0;
        if (!rst) begin
            mq.delete();
            m_regwen = 1'b0; m_waddr = '0; m_wdata = '0;
            m_init = 1'b1;
        end else begin
            rdy = (mq.size() < DEPTH);
            if (alu_valid) begin
                have = 1'b1; sel.rd = alu_rd; sel.d = alu_data;
            end else if (mq.size() > 0) begin
                have = 1'b1; sel = mq.pop_front();
            end else if (lsu_valid) begin
                have = 1'b1; byp = 1'b1; sel.rd = lsu_rd; sel.d = lsu_data;
            end
            if (lsu_valid && rdy && !byp)
                mq.push_back('{rd: lsu_rd, d: lsu_data});
            m_regwen = have && (sel.rd != 5'd0);
            if (m_regwen) begin
                m_waddr = sel.rd; m_wdata = sel.d;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (m_init) begin
            chk("m_regwen", 32'(regwen), 32'(m_regwen));
            chk("m_waddr", 32'(waddr), 32'(m_waddr));
            chk("m_wdata", wdata, m_wdata);
            chk("m_pending", 32'(pending), 32'(mq.size() != 0));
            chk("m_ready", 32'(lsu_ready), 32'(mq.size() < DEPTH));
        end
    endtask

    typedef struct {
        logic        r;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_pend;
        logic        e_rdy;
    } vec_t;

    vec_t vt[13];

    initial begin
        logic acc;
        int   k;

        vt[0]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1};
        vt[1]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7,  32'h12345678, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 1'b1, 5'd3,  32'h11,       1'b1, 5'd8, 32'h22,       1'b1, 5'd3,  32'h11,       1'b1, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd8,  32'h22,       1'b0, 1'b1};
        vt[6]  = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b0, 5'd8,  32'h22,       1'b0, 1'b1};
        vt[7]  = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0, 32'h33,       1'b0, 5'd8,  32'h22,       1'b1, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd8,  32'h22,       1'b0, 1'b1};
        vt[9]  = '{1'b1, 1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd2, 32'h44,       1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 1'b1};
        vt[10] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd4, 32'h55,       1'b1, 5'd2,  32'h44,       1'b1, 1'b1};
        vt[11] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd4,  32'h55,       1'b0, 1'b1};
        vt[12] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd4,  32'h55,       1'b0, 1'b1};

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].r, vt[i].av, vt[i].ard, vt[i].ad, vt[i].lv, vt[i].lrd, vt[i].ld);
            tick();
            chk($sformatf("vec%0d_regwen", i), 32'(regwen), 32'(vt[i].e_wen));
            chk($sformatf("vec%0d_waddr", i), 32'(waddr), 32'(vt[i].e_addr));
            chk($sformatf("vec%0d_wdata", i), wdata, vt[i].e_data);
            chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vt[i].e_pend));
            chk($sformatf("vec%0d_ready", i), 32'(lsu_ready), 32'(vt[i].e_rdy));
        end

        // Contention plus fill, then in-order drain
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        k = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 5'(1 + i), 32'h100 + 32'(i), 1'b1, 5'(10 + k), 32'h200 + 32'(k));
            acc = lsu_valid && lsu_ready;
            tick();
            if (acc) k++;
            chk($sformatf("cont_alu%0d_wen", i), 32'(regwen), 32'd1);
            chk($sformatf("cont_alu%0d_addr", i), 32'(waddr), 32'(1 + i));
            if (i == 3) begin
                chk("fill_ready", 32'(lsu_ready), 32'd0);
                chk("fill_pending", 32'(pending), 32'd1);
                chk("fill_accepts", 32'(k), 32'd4);
            end
        end
        for (int j = 0; j < 6; j++) begin
            if (k < 6)
                drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'(10 + k), 32'h200 + 32'(k));
            else
                drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            acc = lsu_valid && lsu_ready;
            tick();
            if (acc) k++;
            chk($sformatf("drain%0d_wen", j), 32'(regwen), 32'd1);
            chk($sformatf("drain%0d_addr", j), 32'(waddr), 32'(10 + j));
            chk($sformatf("drain%0d_data", j), wdata, 32'h200 + 32'(j));
        end
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("drain_done_wen", 32'(regwen), 32'd0);

        // Reset mid-operation discards queued entries
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'(20 + i), 32'h300 + 32'(i), 1'b1, 5'(24 + i), 32'h400 + 32'(i));
            tick();
        end
        chk("pre_rst_pending", 32'(pending), 32'd1);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("rst_regwen", 32'(regwen), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ready", 32'(lsu_ready), 32'd1);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_rst%0d_wen", i), 32'(regwen), 32'd0);
        end

`ifdef WB_FWD_EN
        drive(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'hA);
        tick();
        drive(1'b1, 1'b1, 5'd2, 32'h2222, 1'b1, 5'd9, 32'hB);
        tick();
        drive(1'b1, 1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'h0);
        fwd_addr = 5'd9;
        #1;
        chk("fwd9_hit", 32'(fwd_hit), 32'd1);
        chk("fwd9_data", fwd_data, 32'hB);
        fwd_addr = 5'd2;
        #1;
        chk("fwd2_hit", 32'(fwd_hit), 32'd1);
        chk("fwd2_data", fwd_data, 32'h2222);
        fwd_addr = 5'd0;
        #1;
        chk("fwd0_hit", 32'(fwd_hit), 32'd0);
        fwd_addr = 5'd17;
        #1;
        chk("fwd_miss_hit", 32'(fwd_hit), 32'd0);
        tick();
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom(),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom());
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
